// File: rtl/sha2_k_sequencer.sv
// sha2_k_sequencer
// Streams the SHA-2 round constants K_0..K_(N-1) to the round core over a
// valid/ready handshake. A single SHA-512 constant table serves both modes:
// a SHA-256 constant is the upper half of the SHA-512 constant at the same
// index, so mode 0 simply presents the upper 32 bits zero-extended.
// Every output comes straight from a register; k_ready only steers the
// next-state logic, never an output.
module sha2_k_sequencer #(
    parameter int K_W       = 64,   // 32 or 64; 32 only together with ALLOW_512 = 0
    parameter bit ALLOW_512 = 1'b1  // 0: 64-round SHA-256 only, mode input ignored
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           mode,
    input  logic           k_ready,
    output logic           k_valid,
    output logic [K_W-1:0] k_out,
    output logic [6:0]     k_idx,
    output logic           k_last,
    output logic           busy,
    output logic           done
);

    // Table depth and address width shrink when only SHA-256 is supported.
    localparam int DEPTH = ALLOW_512 ? 80 : 64;
    localparam int AW    = ALLOW_512 ? 7 : 6;

    // FIPS 180-4 SHA-512 round constants; upper halves are the SHA-256 set.
    localparam logic [63:0] K_TABLE [0:79] = '{
        64'h428a2f98d728ae22, 64'h7137449123ef65cd,
        64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
        64'h3956c25bf348b538, 64'h59f111f1b605d019,
        64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
        64'hd807aa98a3030242, 64'h12835b0145706fbe,
        64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
        64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1,
        64'h9bdc06a725c71235, 64'hc19bf174cf692694,
        64'he49b69c19ef14ad2, 64'hefbe4786384f25e3,
        64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
        64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483,
        64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
        64'h983e5152ee66dfab, 64'ha831c66d2db43210,
        64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
        64'hc6e00bf33da88fc2, 64'hd5a79147930aa725,
        64'h06ca6351e003826f, 64'h142929670a0e6e70,
        64'h27b70a8546d22ffc, 64'h2e1b21385c26c926,
        64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
        64'h650a73548baf63de, 64'h766a0abb3c77b2a8,
        64'h81c2c92e47edaee6, 64'h92722c851482353b,
        64'ha2bfe8a14cf10364, 64'ha81a664bbc423001,
        64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
        64'hd192e819d6ef5218, 64'hd69906245565a910,
        64'hf40e35855771202a, 64'h106aa07032bbd1b8,
        64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53,
        64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
        64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb,
        64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
        64'h748f82ee5defb2fc, 64'h78a5636f43172f60,
        64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
        64'h90befffa23631e28, 64'ha4506cebde82bde9,
        64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
        64'hca273eceea26619c, 64'hd186b8c721c0c207,
        64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
        64'h06f067aa72176fba, 64'h0a637dc5a2c898a6,
        64'h113f9804bef90dae, 64'h1b710b35131c471b,
        64'h28db77f523047d84, 64'h32caab7b40c72493,
        64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
        64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a,
        64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
    };

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic           mode_q, mode_d;
    logic           k_valid_q, k_valid_d;
    logic [K_W-1:0] k_out_q, k_out_d;
    logic [6:0]     k_idx_q, k_idx_d;
    logic           k_last_q, k_last_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic           mode_eff;
    logic           xfer;
    logic [6:0]     last_idx;
    logic [6:0]     rd_idx;
    logic           rd_mode;
    logic [K_W-1:0] rd_word;
    logic [K_W-1:0] rd_k;

    // Stored table holds only the K_W most significant bits of each entry
    // and only as many entries as the widest supported mode needs.
    logic [K_W-1:0] rom_mem [0:DEPTH-1];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_rom
            assign rom_mem[gi] = K_TABLE[gi][63 -: K_W];
        end
    endgenerate

    assign mode_eff = ALLOW_512 && mode;
    assign xfer     = k_valid_q && k_ready;
    assign last_idx = mode_q ? 7'd79 : 7'd63;

    // Constant lookup for whatever index is about to be loaded: K_0 when
    // leaving IDLE, otherwise the successor of the index on the bus.
    always_comb begin
        if (state_q == S_IDLE) begin
            rd_idx  = 7'd0;
            rd_mode = mode_eff;
        end else begin
            rd_idx  = k_idx_q + 7'd1;
            rd_mode = mode_q;
        end
        rd_word = '0;
        if (rd_idx < 7'(DEPTH)) begin
            rd_word = rom_mem[rd_idx[AW-1:0]];
        end
        // Mode 0 takes the upper 32 bits; with K_W=32 the shift is zero.
        rd_k = rd_mode ? rd_word : (rd_word >> (K_W - 32));
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: leave IDLE on start, return after the final transfer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_RUN;
            S_RUN:  if (xfer && k_last_q) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output next-values: everything holds unless a start or transfer moves it.
    always_comb begin
        mode_d    = mode_q;
        k_valid_d = k_valid_q;
        k_out_d   = k_out_q;
        k_idx_d   = k_idx_q;
        k_last_d  = k_last_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                k_valid_d = 1'b0;
                busy_d    = 1'b0;
                if (start) begin
                    mode_d    = mode_eff;
                    k_idx_d   = 7'd0;
                    k_out_d   = rd_k;
                    k_last_d  = 1'b0;
                    k_valid_d = 1'b1;
                    busy_d    = 1'b1;
                end
            end
            S_RUN: begin
                if (xfer) begin
                    if (k_last_q) begin
                        k_valid_d = 1'b0;
                        k_last_d  = 1'b0;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                    end else begin
                        k_idx_d  = rd_idx;
                        k_out_d  = rd_k;
                        k_last_d = (rd_idx == last_idx);
                    end
                end
            end
            default: begin
                k_valid_d = 1'b0;
                busy_d    = 1'b0;
            end
        endcase
    end

    // Output and mode registers; reset clears every output immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q    <= 1'b0;
            k_valid_q <= 1'b0;
            k_out_q   <= '0;
            k_idx_q   <= 7'd0;
            k_last_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            k_valid_q <= k_valid_d;
            k_out_q   <= k_out_d;
            k_idx_q   <= k_idx_d;
            k_last_q  <= k_last_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign k_valid = k_valid_q;
    assign k_out   = k_out_q;
    assign k_idx   = k_idx_q;
    assign k_last  = k_last_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_sha2_k_sequencer.sv
// Testbench for sha2_k_sequencer: a full-featured instance (64-bit, SHA-512
// enabled) and a SHA-256-only instance share all inputs. Expected streams
// come from the FIPS 180-4 constant list and the sequencing rules.
module tb_sha2_k_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic        k_ready = 1'b0;

    logic        a_k_valid, a_k_last, a_busy, a_done;
    logic [63:0] a_k_out;
    logic [6:0]  a_k_idx;
    logic        b_k_valid, b_k_last, b_busy, b_done;
    logic [63:0] b_k_out;
    logic [6:0]  b_k_idx;

    // {valid[74], idx[73:67], out[66:3], last[2], busy[1], done[0]}
    logic [74:0] obs_a, obs_b;
    assign obs_a = {a_k_valid, a_k_idx, a_k_out, a_k_last, a_busy, a_done};
    assign obs_b = {b_k_valid, b_k_idx, b_k_out, b_k_last, b_busy, b_done};

    int total = 0;
    int bad   = 0;

    sha2_k_sequencer #(.K_W(64), .ALLOW_512(1'b1)) dut_a (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .k_ready(k_ready),
        .k_valid(a_k_valid), .k_out(a_k_out), .k_idx(a_k_idx),
        .k_last(a_k_last), .busy(a_busy), .done(a_done)
    );

    sha2_k_sequencer #(.K_W(64), .ALLOW_512(1'b0)) dut_b (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .k_ready(k_ready),
        .k_valid(b_k_valid), .k_out(b_k_out), .k_idx(b_k_idx),
        .k_last(b_k_last), .busy(b_busy), .done(b_done)
    );

    always #5 clk = ~clk;

    localparam logic [63:0] KT [0:79] = '{
        64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
        64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
        64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
        64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
        64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
        64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
        64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
        64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
        64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
        64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
        64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
        64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
        64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
        64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
        64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
        64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
        64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
        64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
        64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
        64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
    };

    // Reference constant: SHA-256 is the upper half, zero-extended.
    function automatic logic [63:0] exp_k(int t, bit m);
        logic [63:0] full;
        full = KT[t];
        return m ? full : {32'h0, full[63:32]};
    endfunction

    // Expected bus in cycle c (1-based) of an unstalled n-constant run.
    function automatic logic [74:0] exp_vec(int c, int n, bit m);
        return {1'b1, 7'(c - 1), exp_k(c - 1, m), (c == n), 1'b1, 1'b0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; k_ready = 1'b0; mode = 1'b0;
        tick(); tick();
        total++; if (obs_a !== 75'd0) begin bad++; $display("FAIL reset_hold got=%h want=0", obs_a); end
        rst = 1'b0;
        repeat (3) tick();
        total++; if (obs_a !== 75'd0) begin bad++; $display("FAIL reset_idle_a got=%h want=0", obs_a); end
        total++; if (obs_b !== 75'd0) begin bad++; $display("FAIL reset_idle_b got=%h want=0", obs_b); end
        // Asynchronous reset in the middle of a cycle while a run is active.
        mode = 1'b1; k_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        total++; if (obs_a !== exp_vec(5, 80, 1'b1)) begin bad++; $display("FAIL reset_prerun got=%h want=%h", obs_a, exp_vec(5, 80, 1'b1)); end
        #3 rst = 1'b1;
        #1;
        total++; if (obs_a !== 75'd0) begin bad++; $display("FAIL reset_async_a got=%h want=0", obs_a); end
        total++; if (obs_b !== 75'd0) begin bad++; $display("FAIL reset_async_b got=%h want=0", obs_b); end
        @(negedge clk) rst = 1'b0;
        repeat (3) tick();
        total++; if (obs_a !== 75'd0) begin bad++; $display("FAIL reset_release got=%h want=0", obs_a); end
        $display("test_reset: done");
    endtask

    task automatic test_mode0_full();
        mode = 1'b0; k_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 64; c++) begin
            total++; if (obs_a !== exp_vec(c, 64, 1'b0)) begin bad++; $display("FAIL m0_run_a c=%0d got=%h want=%h", c, obs_a, exp_vec(c, 64, 1'b0)); end
            total++; if (obs_b !== exp_vec(c, 64, 1'b0)) begin bad++; $display("FAIL m0_run_b c=%0d got=%h want=%h", c, obs_b, exp_vec(c, 64, 1'b0)); end
            tick();
        end
        total++; if ({obs_a[74], obs_a[2:0]} !== 4'b0001) begin bad++; $display("FAIL m0_done_a got=%b want=0001", {obs_a[74], obs_a[2:0]}); end
        total++; if ({obs_b[74], obs_b[2:0]} !== 4'b0001) begin bad++; $display("FAIL m0_done_b got=%b want=0001", {obs_b[74], obs_b[2:0]}); end
        tick();
        total++; if ({obs_a[74], obs_a[2:0]} !== 4'b0000) begin bad++; $display("FAIL m0_after got=%b want=0000", {obs_a[74], obs_a[2:0]}); end
        $display("test_mode0_full: 64 constants streamed");
    endtask

    task automatic test_mode1_full();
        mode = 1'b1; k_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        mode = 1'b0;
        for (int c = 1; c <= 82; c++) begin
            if (c <= 80) begin
                total++; if (obs_a !== exp_vec(c, 80, 1'b1)) begin bad++; $display("FAIL m1_run_a c=%0d got=%h want=%h", c, obs_a, exp_vec(c, 80, 1'b1)); end
            end else begin
                total++; if ({obs_a[74], obs_a[2:0]} !== {3'b000, (c == 81)}) begin bad++; $display("FAIL m1_tail_a c=%0d got=%b", c, {obs_a[74], obs_a[2:0]}); end
            end
            if (c <= 64) begin
                total++; if (obs_b !== exp_vec(c, 64, 1'b0)) begin bad++; $display("FAIL m1_only256_b c=%0d got=%h want=%h", c, obs_b, exp_vec(c, 64, 1'b0)); end
            end else if (c <= 66) begin
                total++; if ({obs_b[74], obs_b[2:0]} !== {3'b000, (c == 65)}) begin bad++; $display("FAIL m1_tail_b c=%0d got=%b", c, {obs_b[74], obs_b[2:0]}); end
            end
            tick();
        end
        $display("test_mode1_full: 80 constants streamed, 256-only instance gave 64");
    endtask

    task automatic test_back_to_back();
        mode = 1'b0; k_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (64) tick();
        total++; if ({obs_a[74], obs_a[2:0]} !== 4'b0001) begin bad++; $display("FAIL b2b_done1 got=%b want=0001", {obs_a[74], obs_a[2:0]}); end
        start = 1'b1;
        tick();
        start = 1'b0;
        total++; if (obs_a !== exp_vec(1, 64, 1'b0)) begin bad++; $display("FAIL b2b_restart got=%h want=%h", obs_a, exp_vec(1, 64, 1'b0)); end
        repeat (63) tick();
        total++; if (obs_a !== exp_vec(64, 64, 1'b0)) begin bad++; $display("FAIL b2b_last got=%h want=%h", obs_a, exp_vec(64, 64, 1'b0)); end
        tick();
        total++; if ({obs_a[74], obs_a[2:0]} !== 4'b0001) begin bad++; $display("FAIL b2b_done2 got=%b want=0001", {obs_a[74], obs_a[2:0]}); end
        tick();
        $display("test_back_to_back: restart on done cycle");
    endtask

    task automatic test_backpressure(bit m);
        int          n = 0;
        int          nexp;
        int          dones = 0;
        int          post = 0;
        bit          prev_stall = 1'b0;
        bit          rdy;
        logic [74:0] prev;
        nexp = m ? 80 : 64;
        prev = '0;
        mode = m; k_ready = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 0; cyc < 2000 && post < 3; cyc++) begin
            if (dones > 0) post++;
            if (a_done) begin
                dones++;
                total++; if (a_k_valid !== 1'b0) begin bad++; $display("FAIL bp_done_valid got=%b want=0", a_k_valid); end
            end
            if (prev_stall) begin
                total++; if (obs_a[74:2] !== prev[74:2]) begin bad++; $display("FAIL bp_stall got=%h want=%h", obs_a[74:2], prev[74:2]); end
            end
            if (a_k_valid) begin
                if (n >= nexp) begin
                    total++; bad++; $display("FAIL bp_extra idx=%0d want_none", a_k_idx);
                end else begin
                    total++; if ({a_k_idx, a_k_out, a_k_last} !== {7'(n), exp_k(n, m), (n == nexp - 1)}) begin
                        bad++; $display("FAIL bp_data n=%0d got=%0d/%h/%b want=%0d/%h/%b", n, a_k_idx, a_k_out, a_k_last, n, exp_k(n, m), (n == nexp - 1));
                    end
                end
            end
            rdy = 1'($urandom_range(0, 1));
            k_ready = rdy;
            prev_stall = a_k_valid && !rdy;
            prev = obs_a;
            if (a_k_valid && rdy) n++;
            tick();
        end
        k_ready = 1'b0;
        total++; if (n !== nexp) begin bad++; $display("FAIL bp_count got=%0d want=%0d", n, nexp); end
        total++; if (dones !== 1) begin bad++; $display("FAIL bp_dones got=%0d want=1", dones); end
        $display("test_backpressure: mode=%0d received=%0d", m, n);
    endtask

    task automatic test_ignored_inputs();
        int n = 0;
        int dones = 0;
        int post = 0;
        bit pulsed = 1'b0;
        mode = 1'b0; k_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 0; cyc < 300 && post < 3; cyc++) begin
            if (dones > 0) post++;
            if (a_done) dones++;
            if (a_k_valid) begin
                total++; if ({a_k_idx, a_k_out, a_k_last} !== {7'(n), exp_k(n, 1'b0), (n == 63)}) begin
                    bad++; $display("FAIL ign_data n=%0d got=%0d/%h want=%0d/%h", n, a_k_idx, a_k_out, n, exp_k(n, 1'b0));
                end
                n++;
            end
            start = 1'b0;
            if (a_k_valid && a_k_idx == 7'd10 && !pulsed) begin
                start = 1'b1;
                pulsed = 1'b1;
            end
            if (pulsed && a_k_valid) mode = ~mode;
            tick();
        end
        start = 1'b0; mode = 1'b0;
        total++; if (n !== 64) begin bad++; $display("FAIL ign_count got=%0d want=64", n); end
        total++; if (dones !== 1) begin bad++; $display("FAIL ign_dones got=%0d want=1", dones); end
        $display("test_ignored_inputs: received=%0d dones=%0d", n, dones);
    endtask

    task automatic test_reset_midrun();
        bit found = 1'b0;
        int stray = 0;
        mode = 1'b0; k_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (a_k_valid && a_k_idx == 7'd20) found = 1'b1;
            else tick();
        end
        total++; if (!found) begin bad++; $display("FAIL rmid_reach got=none want=idx20"); end
        #2 rst = 1'b1;
        #1;
        total++; if (obs_a !== 75'd0) begin bad++; $display("FAIL rmid_clear got=%h want=0", obs_a); end
        @(negedge clk) rst = 1'b0;
        tick();
        for (int i = 0; i < 70; i++) begin
            if (a_done || a_k_valid || b_done || b_k_valid) stray++;
            tick();
        end
        total++; if (stray !== 0) begin bad++; $display("FAIL rmid_nodone got=%0d want=0", stray); end
        mode = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        total++; if (obs_b !== exp_vec(1, 64, 1'b0)) begin bad++; $display("FAIL rmid_restart_b got=%h want=%h", obs_b, exp_vec(1, 64, 1'b0)); end
        for (int c = 1; c <= 80; c++) begin
            total++; if (obs_a !== exp_vec(c, 80, 1'b1)) begin bad++; $display("FAIL rmid_run c=%0d got=%h want=%h", c, obs_a, exp_vec(c, 80, 1'b1)); end
            tick();
        end
        total++; if ({obs_a[74], obs_a[2:0]} !== 4'b0001) begin bad++; $display("FAIL rmid_done got=%b want=0001", {obs_a[74], obs_a[2:0]}); end
        tick();
        $display("test_reset_midrun: aborted at t=20, restarted cleanly");
    endtask

    initial begin
        test_reset();
        test_mode0_full();
        test_mode1_full();
        test_back_to_back();
        test_backpressure(1'b0);
        test_backpressure(1'b1);
        test_ignored_inputs();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
